// File: rtl/mk_ehr_regfile.sv
// Register file with two ordered write ports, a w0->r1 bypass and a hardware clear sequencer.
// Optional feature: define RF_ZERO_REG_EN to hardwire entry 0 to zero.
module mk_ehr_regfile #(
    parameter int               size  = 5,
    parameter int               width = 32,
    parameter logic [width-1:0] init  = '0
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic [size-1:0]  r0_x,
    output logic [width-1:0] r0,
    output logic             RDY_r0,
    input  logic [size-1:0]  w0_x,
    input  logic [width-1:0] w0_y,
    input  logic             EN_w0,
    output logic             RDY_w0,
    input  logic [size-1:0]  r1_x,
    output logic [width-1:0] r1,
    output logic             RDY_r1,
    input  logic [size-1:0]  w1_x,
    input  logic [width-1:0] w1_y,
    input  logic             EN_w1,
    output logic             RDY_w1,
    input  logic             EN_clr,
    output logic             RDY_clr
);
    localparam int            DEPTH    = 1 << size;
    localparam logic [size-1:0] LAST_IDX = {size{1'b1}};

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [size-1:0]  r_ptr;
    logic [size-1:0]  w_ptr_nxt;
    logic [width-1:0] r_d [DEPTH];

    logic w_rdy;
    logic w_we0;
    logic w_we1;
    logic w_clr_go;
    logic w_byp;

    assign w_rdy    = (r_state == ST_READY);
    assign w_clr_go = EN_clr && w_rdy;

    assign RDY_r0  = w_rdy;
    assign RDY_r1  = w_rdy;
    assign RDY_w0  = w_rdy;
    assign RDY_w1  = w_rdy;
    assign RDY_clr = w_rdy;

`ifdef RF_ZERO_REG_EN
    // Writes to entry 0 are dropped entirely, including the r1 bypass.
    assign w_we0 = EN_w0 && w_rdy && (w0_x != '0);
    assign w_we1 = EN_w1 && w_rdy && (w1_x != '0);
`else
    assign w_we0 = EN_w0 && w_rdy;
    assign w_we1 = EN_w1 && w_rdy;
`endif

    assign w_byp = w_we0 && (w0_x == r1_x);

    always_comb begin
        w_state_nxt = r_state;
        w_ptr_nxt   = r_ptr;
        case (r_state)
            ST_CLEAR: begin
                w_ptr_nxt = r_ptr + 1'b1;
                if (r_ptr == LAST_IDX) begin
                    w_state_nxt = ST_READY;
                end
            end
            ST_READY: begin
                if (w_clr_go) begin
                    w_state_nxt = ST_CLEAR;
                    w_ptr_nxt   = '0;
                end
            end
            default: begin
                w_state_nxt = ST_CLEAR;
                w_ptr_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            r_state <= ST_CLEAR;
            r_ptr   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_ptr   <= w_ptr_nxt;
        end
    end

    // w1 is assigned after w0 so it wins on an address collision.
    always_ff @(posedge CLK) begin
        if (r_state == ST_CLEAR) begin
            r_d[r_ptr] <= init;
        end else begin
            if (w_we0) begin
                r_d[w0_x] <= w0_y;
            end
            if (w_we1) begin
                r_d[w1_x] <= w1_y;
            end
        end
    end

    always_comb begin
        r0 = r_d[r0_x];
        r1 = w_byp ? w0_y : r_d[r1_x];
`ifdef RF_ZERO_REG_EN
        if (r0_x == '0) begin
            r0 = '0;
        end
        if (r1_x == '0) begin
            r1 = '0;
        end
`endif
    end

endmodule

// File: tb/tb_mk_ehr_regfile.sv
// Scoreboard bench for mk_ehr_regfile (size=3, width=8, init=8'hA5).
module tb_mk_ehr_regfile;
    localparam int         SZ   = 3;
    localparam int         W    = 8;
    localparam logic [7:0] INIT = 8'hA5;
    localparam int         K_R0 = 0;
    localparam int         K_R1 = 1;
    localparam int         K_RDY = 2;

    logic          CLK = 1'b0;
    logic          RST_N;
    logic [SZ-1:0] r0_x, r1_x, w0_x, w1_x;
    logic [W-1:0]  r0, r1, w0_y, w1_y;
    logic          EN_w0, EN_w1, EN_clr;
    logic          RDY_r0, RDY_r1, RDY_w0, RDY_w1, RDY_clr;

    mk_ehr_regfile #(.size(SZ), .width(W), .init(INIT)) dut (
        .CLK(CLK), .RST_N(RST_N),
        .r0_x(r0_x), .r0(r0), .RDY_r0(RDY_r0),
        .w0_x(w0_x), .w0_y(w0_y), .EN_w0(EN_w0), .RDY_w0(RDY_w0),
        .r1_x(r1_x), .r1(r1), .RDY_r1(RDY_r1),
        .w1_x(w1_x), .w1_y(w1_y), .EN_w1(EN_w1), .RDY_w1(RDY_w1),
        .EN_clr(EN_clr), .RDY_clr(RDY_clr)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        int         cyc;
        int         kind;
        logic [7:0] exp;
        string      name;
    } exp_t;

    exp_t sb[$];
    exp_t m_e;
    int   cyc    = 0;
    int   n_chk  = 0;
    int   n_pass = 0;
    logic [7:0] m_act;

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic expect_out(input int kind, input logic [7:0] v, input string name);
        exp_t e;
        e.cyc  = cyc;
        e.kind = kind;
        e.exp  = v;
        e.name = name;
        sb.push_back(e);
    endtask

    // Monitor: compare every expectation queued for the current cycle.
    always @(negedge CLK) begin
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            m_e = sb.pop_front();
            case (m_e.kind)
                K_R0:    m_act = r0;
                K_R1:    m_act = r1;
                default: m_act = {3'b000, RDY_r0, RDY_r1, RDY_w0, RDY_w1, RDY_clr};
            endcase
            n_chk++;
            if (m_e.cyc != cyc || m_act !== m_e.exp)
                $display("FAIL %s (cycle %0d): got %h expected %h", m_e.name, m_e.cyc, m_act, m_e.exp);
            else
                n_pass++;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        RST_N = 1'b0;
        r0_x = '0; r1_x = '0; w0_x = '0; w1_x = '0;
        w0_y = '0; w1_y = '0;
        EN_w0 = 1'b0; EN_w1 = 1'b0; EN_clr = 1'b0;

        step();
        RST_N = 1'b1;
        for (int i = 0; i < 8; i++) begin
            expect_out(K_RDY, 8'h00, "rdy_low_after_reset");
            step();
        end
        expect_out(K_RDY, 8'h1F, "rdy_high_after_reset");

        for (int i = 0; i < 8; i++) begin
            r0_x = SZ'(i);
`ifdef RF_ZERO_REG_EN
            expect_out(K_R0, (i == 0) ? 8'h00 : INIT, "init_read");
`else
            expect_out(K_R0, INIT, "init_read");
`endif
            step();
        end

        // Same-cycle bypass to r1, then visible on r0.
        EN_w0 = 1'b1; w0_x = 3'd2; w0_y = 8'd11; r1_x = 3'd2;
        expect_out(K_R1, 8'd11, "r1_bypass");
        step();
        EN_w0 = 1'b0; r0_x = 3'd2; r1_x = 3'd3;
        expect_out(K_R0, 8'd11, "r0_after_w0");
        expect_out(K_R1, INIT, "r1_other_addr");
        step();

        // No bypass when addresses differ.
        EN_w0 = 1'b1; w0_x = 3'd5; w0_y = 8'h33; r1_x = 3'd6;
        expect_out(K_R1, INIT, "r1_no_bypass");
        step();
        EN_w0 = 1'b0; r0_x = 3'd5;
        expect_out(K_R0, 8'h33, "r0_after_w0_b");
        step();

        // Collision: w1 wins in the array, r1 bypass shows w0.
        EN_w0 = 1'b1; w0_x = 3'd4; w0_y = 8'd1;
        EN_w1 = 1'b1; w1_x = 3'd4; w1_y = 8'd2; r1_x = 3'd4;
        expect_out(K_R1, 8'd1, "r1_bypass_w0_only");
        step();
        EN_w0 = 1'b0; EN_w1 = 1'b0; r0_x = 3'd4;
        expect_out(K_R0, 8'd2, "w1_wins");
        step();

        // Clear request together with a w1 write.
        EN_clr = 1'b1; EN_w1 = 1'b1; w1_x = 3'd1; w1_y = 8'd7;
        expect_out(K_RDY, 8'h1F, "rdy_before_clr");
        step();
        EN_clr = 1'b0; EN_w1 = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (i == 7) begin
                EN_w0 = 1'b1; w0_x = 3'd0; w0_y = 8'h44;
            end
            expect_out(K_RDY, 8'h00, "rdy_low_clr");
            step();
        end
        EN_w0 = 1'b0;
        r0_x = 3'd1; r1_x = 3'd2;
        expect_out(K_RDY, 8'h1F, "rdy_high_after_clr");
        expect_out(K_R0, INIT, "addr1_cleared");
        expect_out(K_R1, INIT, "addr2_cleared");
        step();
        r0_x = 3'd0;
`ifdef RF_ZERO_REG_EN
        expect_out(K_R0, 8'h00, "w0_ignored_in_clear");
`else
        expect_out(K_R0, INIT, "w0_ignored_in_clear");
`endif
        step();

        // Reset in cycle 3 of a clear restarts the sequence.
        EN_clr = 1'b1;
        expect_out(K_RDY, 8'h1F, "rdy_before_clr2");
        step();
        EN_clr = 1'b0;
        expect_out(K_RDY, 8'h00, "clr2_c1");
        step();
        expect_out(K_RDY, 8'h00, "clr2_c2");
        step();
        RST_N = 1'b0;
        expect_out(K_RDY, 8'h00, "clr2_c3_reset");
        step();
        RST_N = 1'b1;
        for (int i = 0; i < 8; i++) begin
            expect_out(K_RDY, 8'h00, "rdy_low_restart");
            step();
        end
        r0_x = 3'd3;
        expect_out(K_RDY, 8'h1F, "rdy_high_restart");
        expect_out(K_R0, INIT, "addr3_after_restart");
        step();

        // Write to address 0 with r1 reading address 0.
        EN_w0 = 1'b1; w0_x = 3'd0; w0_y = 8'd9; r1_x = 3'd0;
`ifdef RF_ZERO_REG_EN
        expect_out(K_R1, 8'h00, "zero_reg_r1");
`else
        expect_out(K_R1, 8'd9, "addr0_r1_bypass");
`endif
        step();
        EN_w0 = 1'b0; r0_x = 3'd0;
`ifdef RF_ZERO_REG_EN
        expect_out(K_R0, 8'h00, "zero_reg_r0");
`else
        expect_out(K_R0, 8'd9, "addr0_r0");
`endif
        step();

        for (int i = 0; i < 20 && sb.size() > 0; i++) step();
        if (sb.size() > 0) begin
            n_chk++;
            $display("FAIL scoreboard_drain: %0d entries left, required 0", sb.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
